id_stage: RTL and testbench

Decode and operand-fetch stage of the pipelined core; sits between the IF/ID register and EX and owns the ID/EX pipeline register. It decodes the instruction and drives the register-file read addresses. It resolves operands by bypassing from EX, MEM and WB, and inserts one-cycle bubbles on load-use hazards. The register file reads combinationally and writes on the clock edge, so a same-cycle WB write is not visible through it; this block supplies that value via the WB bypass.

---
 rtl/id_stage_if.sv | 71 +++++++
 rtl/id_stage.sv | 191 +++++++++++++++++++
 tb/tb_id_stage.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// Bundle of the decode stage's pipeline-facing signals: IF/ID input, register-file
// read port, EX/MEM/WB bypass sources and the ID/EX register outputs.
interface id_stage_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;

    logic [4:0]      rf_ra1;
    logic [4:0]      rf_ra2;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;

    logic            ex_ready;
    logic            flush;
    logic [XLEN-1:0] ex_result;

    logic            mem_we;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;

    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            idex_valid;
    logic [XLEN-1:0] idex_pc;
    logic [XLEN-1:0] idex_rs1_val;
    logic [XLEN-1:0] idex_rs2_val;
    logic [XLEN-1:0] idex_imm;
    logic [4:0]      idex_rs1;
    logic [4:0]      idex_rs2;
    logic [4:0]      idex_rd;
    logic [6:0]      idex_opcode;
    logic [2:0]      idex_funct3;
    logic            idex_funct7b5;
    logic            idex_we;
    logic            idex_is_load;
    logic            idex_is_store;
    logic            idex_illegal;
    logic [31:0]     stall_count;

    // The decode stage itself is the master of this bundle.
    modport master (
        input  if_valid, if_instr, if_pc,
        input  rf_rd1, rf_rd2,
        input  ex_ready, flush, ex_result,
        input  mem_we, mem_rd, mem_data,
        input  wb_we, wb_rd, wb_data,
        output id_ready, rf_ra1, rf_ra2,
        output idex_valid, idex_pc, idex_rs1_val, idex_rs2_val, idex_imm,
        output idex_rs1, idex_rs2, idex_rd, idex_opcode, idex_funct3,
        output idex_funct7b5, idex_we, idex_is_load, idex_is_store, idex_illegal,
        output stall_count
    );

    modport slave (
        output if_valid, if_instr, if_pc,
        output rf_rd1, rf_rd2,
        output ex_ready, flush, ex_result,
        output mem_we, mem_rd, mem_data,
        output wb_we, wb_rd, wb_data,
        input  id_ready, rf_ra1, rf_ra2,
        input  idex_valid, idex_pc, idex_rs1_val, idex_rs2_val, idex_imm,
        input  idex_rs1, idex_rs2, idex_rd, idex_opcode, idex_funct3,
        input  idex_funct7b5, idex_we, idex_is_load, idex_is_store, idex_illegal,
        input  stall_count
    );
endinterface

// File: rtl/id_stage.sv
// Decode / operand-fetch stage: decodes the IF/ID instruction, bypasses operands from
// EX, MEM and WB, inserts load-use bubbles and owns the ID/EX pipeline register.
module id_stage #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    id_stage_if.master bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0]            instr;
    logic [6:0]             opcode;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [4:0]             rd;
    logic signed [XLEN-1:0] imm_d;
    logic                   we_d;
    logic                   illegal_d;
    logic                   use_rs1;
    logic                   use_rs2;
    logic [XLEN-1:0]        rs1_val_d;
    logic [XLEN-1:0]        rs2_val_d;
    logic                   hazard;
    logic                   adv;

    logic                   vld_p1;
    logic [XLEN-1:0]        pc_p1;
    logic [XLEN-1:0]        rs1_val_p1;
    logic [XLEN-1:0]        rs2_val_p1;
    logic signed [XLEN-1:0] imm_p1;
    logic [4:0]             rs1_p1;
    logic [4:0]             rs2_p1;
    logic [4:0]             rd_p1;
    logic [6:0]             opcode_p1;
    logic [2:0]             funct3_p1;
    logic                   funct7b5_p1;
    logic                   we_p1;
    logic                   is_load_p1;
    logic                   is_store_p1;
    logic                   illegal_p1;
    logic [XLEN-1:0]        stall_cnt;

    function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
        return (&v) ? v : v + XLEN'(1);
    endfunction

    // Youngest producer wins; a load in EX has no result yet and is left to the hazard logic.
    function automatic logic [XLEN-1:0] operand(input logic [4:0] rs,
                                                 input logic [XLEN-1:0] rf_val);
        if (rs == 5'd0)
            return '0;
        else if (vld_p1 && we_p1 && !is_load_p1 && (rd_p1 == rs))
            return bus.ex_result;
        else if (bus.mem_we && (bus.mem_rd == rs))
            return bus.mem_data;
        else if (bus.wb_we && (bus.wb_rd == rs))
            return bus.wb_data;
        else
            return rf_val;
    endfunction

    assign instr  = bus.if_instr;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    always_comb begin
        imm_d     = '0;
        we_d      = 1'b0;
        illegal_d = 1'b0;
        use_rs1   = 1'b1;
        use_rs2   = 1'b0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: begin
                imm_d = $signed({{20{instr[31]}}, instr[31:20]});
                we_d  = 1'b1;
            end
            OP_STORE: begin
                imm_d   = $signed({{20{instr[31]}}, instr[31:25], instr[11:7]});
                use_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                imm_d   = $signed({{19{instr[31]}}, instr[31], instr[7],
                                   instr[30:25], instr[11:8], 1'b0});
                use_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm_d   = $signed({instr[31:12], 12'b0});
                we_d    = 1'b1;
                use_rs1 = 1'b0;
            end
            OP_JAL: begin
                imm_d   = $signed({{11{instr[31]}}, instr[31], instr[19:12],
                                   instr[20], instr[30:21], 1'b0});
                we_d    = 1'b1;
                use_rs1 = 1'b0;
            end
            OP_REG: begin
                we_d    = 1'b1;
                use_rs2 = 1'b1;
            end
            default: illegal_d = 1'b1;
        endcase
    end

    always_comb begin
        rs1_val_d = operand(rs1, bus.rf_rd1);
        rs2_val_d = operand(rs2, bus.rf_rd2);
    end

    assign adv    = !vld_p1 || bus.ex_ready;
    assign hazard = bus.if_valid && vld_p1 && is_load_p1 && (rd_p1 != 5'd0) &&
                    ((use_rs1 && (rd_p1 == rs1)) || (use_rs2 && (rd_p1 == rs2)));

    // Flush always drains IF/ID, even while EX is stalled or a hazard is pending.
    assign bus.id_ready = bus.flush || (adv && !hazard);
    assign bus.rf_ra1   = rs1;
    assign bus.rf_ra2   = rs2;

    // ---- ID -> EX boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            rs1_val_p1  <= '0;
            rs2_val_p1  <= '0;
            imm_p1      <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rd_p1       <= '0;
            opcode_p1   <= '0;
            funct3_p1   <= '0;
            funct7b5_p1 <= 1'b0;
            we_p1       <= 1'b0;
            is_load_p1  <= 1'b0;
            is_store_p1 <= 1'b0;
            illegal_p1  <= 1'b0;
            stall_cnt   <= '0;
        end else if (bus.flush) begin
            vld_p1 <= 1'b0;
        end else if (adv) begin
            if (hazard) begin
                vld_p1    <= 1'b0;
                stall_cnt <= sat_inc(stall_cnt);
            end else begin
                vld_p1      <= bus.if_valid;
                pc_p1       <= bus.if_pc;
                rs1_val_p1  <= rs1_val_d;
                rs2_val_p1  <= rs2_val_d;
                imm_p1      <= imm_d;
                rs1_p1      <= rs1;
                rs2_p1      <= rs2;
                rd_p1       <= rd;
                opcode_p1   <= opcode;
                funct3_p1   <= instr[14:12];
                funct7b5_p1 <= instr[30];
                we_p1       <= we_d;
                is_load_p1  <= (opcode == OP_LOAD);
                is_store_p1 <= (opcode == OP_STORE);
                illegal_p1  <= illegal_d;
            end
        end
    end

    assign bus.idex_valid    = vld_p1;
    assign bus.idex_pc       = pc_p1;
    assign bus.idex_rs1_val  = rs1_val_p1;
    assign bus.idex_rs2_val  = rs2_val_p1;
    assign bus.idex_imm      = imm_p1;
    assign bus.idex_rs1      = rs1_p1;
    assign bus.idex_rs2      = rs2_p1;
    assign bus.idex_rd       = rd_p1;
    assign bus.idex_opcode   = opcode_p1;
    assign bus.idex_funct3   = funct3_p1;
    assign bus.idex_funct7b5 = funct7b5_p1;
    assign bus.idex_we       = we_p1;
    assign bus.idex_is_load  = is_load_p1;
    assign bus.idex_is_store = is_store_p1;
    assign bus.idex_illegal  = illegal_p1;
    assign bus.stall_count   = stall_cnt;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized traffic checked against a
// transaction-level model of the decode stage and its ID/EX register.
module tb_id_stage;
    localparam logic [6:0] O_LOAD   = 7'b0000011;
    localparam logic [6:0] O_IMM    = 7'b0010011;
    localparam logic [6:0] O_JALR   = 7'b1100111;
    localparam logic [6:0] O_STORE  = 7'b0100011;
    localparam logic [6:0] O_BRANCH = 7'b1100011;
    localparam logic [6:0] O_LUI    = 7'b0110111;
    localparam logic [6:0] O_AUIPC  = 7'b0010111;
    localparam logic [6:0] O_JAL    = 7'b1101111;
    localparam logic [6:0] O_REG    = 7'b0110011;

    localparam logic [31:0] I_ADDI_X5_M1 = 32'hFFF00293;
    localparam logic [31:0] I_ADDI_X1_5  = 32'h00500093;
    localparam logic [31:0] I_ADDI_X7_3  = 32'h00300393;
    localparam logic [31:0] I_ADD_X3     = 32'h002081B3;
    localparam logic [31:0] I_LW_X4      = 32'h0000A203;
    localparam logic [31:0] I_ADD_X6     = 32'h00420333;
    localparam logic [31:0] I_LUI_X4     = 32'h12345237;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7b5;
        logic        we;
        logic        ld;
        logic        st;
        logic        ill;
    } idex_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_stage_if bus ();
    id_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

    logic [31:0] regs [32];
    assign bus.rf_rd1 = regs[bus.rf_ra1];
    assign bus.rf_rd2 = regs[bus.rf_ra2];

    int checks = 0;
    int failures = 0;
    idex_t m;
    logic [31:0] m_stall;

    function automatic idex_t dut_now();
        idex_t d;
        d.valid = bus.idex_valid;   d.pc = bus.idex_pc;
        d.v1 = bus.idex_rs1_val;    d.v2 = bus.idex_rs2_val;
        d.imm = bus.idex_imm;       d.rs1 = bus.idex_rs1;
        d.rs2 = bus.idex_rs2;       d.rd = bus.idex_rd;
        d.op = bus.idex_opcode;     d.f3 = bus.idex_funct3;
        d.f7b5 = bus.idex_funct7b5; d.we = bus.idex_we;
        d.ld = bus.idex_is_load;    d.st = bus.idex_is_store;
        d.ill = bus.idex_illegal;
        return d;
    endfunction

    // Immediates computed arithmetically from the encoding rules.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int v;
        case (ins[6:0])
            O_LOAD, O_IMM, O_JALR: v = $signed(ins) >>> 20;
            O_STORE:  v = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
            O_BRANCH: v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 +
                          int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            O_LUI, O_AUIPC: v = int'(ins & 32'hFFFFF000);
            O_JAL:    v = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 +
                          int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            default:  v = 0;
        endcase
        return v;
    endfunction

    function automatic logic uses1(input logic [6:0] op);
        return !(op inside {O_LUI, O_AUIPC, O_JAL});
    endfunction
    function automatic logic uses2(input logic [6:0] op);
        return op inside {O_REG, O_STORE, O_BRANCH};
    endfunction

    function automatic logic [31:0] ref_opnd(input logic [4:0] rs);
        if (rs == 0) return 32'h0;
        if (m.valid && m.we && !m.ld && m.rd == rs) return bus.ex_result;
        if (bus.mem_we && bus.mem_rd == rs) return bus.mem_data;
        if (bus.wb_we && bus.wb_rd == rs) return bus.wb_data;
        return regs[rs];
    endfunction

    function automatic logic ref_hazard();
        logic [31:0] ins = bus.if_instr;
        return bus.if_valid && m.valid && m.ld && m.rd != 0 &&
               ((uses1(ins[6:0]) && m.rd == ins[19:15]) ||
                (uses2(ins[6:0]) && m.rd == ins[24:20]));
    endfunction

    function automatic logic ref_ready();
        return bus.flush || ((!m.valid || bus.ex_ready) && !ref_hazard());
    endfunction

    function automatic idex_t ref_decode();
        idex_t n;
        logic [31:0] ins = bus.if_instr;
        n.valid = bus.if_valid;
        n.pc = bus.if_pc;
        n.v1 = ref_opnd(ins[19:15]);
        n.v2 = ref_opnd(ins[24:20]);
        n.imm = ref_imm(ins);
        n.rs1 = ins[19:15]; n.rs2 = ins[24:20]; n.rd = ins[11:7];
        n.op = ins[6:0]; n.f3 = ins[14:12]; n.f7b5 = ins[30];
        n.we = ins[6:0] inside {O_REG, O_IMM, O_LOAD, O_JAL, O_JALR, O_LUI, O_AUIPC};
        n.ill = !(ins[6:0] inside {O_REG, O_IMM, O_LOAD, O_JAL, O_JALR, O_LUI, O_AUIPC,
                                   O_STORE, O_BRANCH});
        n.ld = ins[6:0] == O_LOAD;
        n.st = ins[6:0] == O_STORE;
        return n;
    endfunction

    // Advance the model and the clock by one cycle; ends 1ns after the edge.
    task automatic tick();
        idex_t n = m;
        logic [31:0] ns = m_stall;
        if (bus.flush) begin
            n.valid = 1'b0;
        end else if (!m.valid || bus.ex_ready) begin
            if (ref_hazard()) begin
                n.valid = 1'b0;
                if (ns != 32'hFFFFFFFF) ns = ns + 1;
            end else begin
                n = ref_decode();
            end
        end
        @(posedge clk);
        #1;
        m = n;
        m_stall = ns;
    endtask

    task automatic idle();
        bus.if_valid = 1'b0; bus.flush = 1'b0; bus.ex_ready = 1'b1;
        bus.mem_we = 1'b0; bus.wb_we = 1'b0;
        tick();
        tick();
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] pc);
        bus.if_valid = 1'b1;
        bus.if_instr = ins;
        bus.if_pc = pc;
    endtask

    task automatic test_reset();
        bus.if_valid = 1'b1; bus.if_instr = I_ADDI_X5_M1; bus.if_pc = 32'h40;
        bus.flush = 1'b0; bus.ex_ready = 1'b1; bus.ex_result = '0;
        bus.mem_we = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        rst_n = 1'b0;
        #12;
        checks++;
        if (dut_now() !== idex_t'(0)) begin
            failures++;
            $display("FAIL reset_idex got=%h exp=0", dut_now());
        end
        checks++;
        if (bus.stall_count !== 32'h0) begin
            failures++;
            $display("FAIL reset_stall got=%h exp=0", bus.stall_count);
        end
        checks++;
        if (bus.id_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_id_ready got=%b exp=1", bus.id_ready);
        end
        #1 rst_n = 1'b1;
        m = '0;
        m_stall = '0;
        bus.if_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_addi();
        present(I_ADDI_X5_M1, 32'h100);
        #1;
        checks++;
        if (bus.id_ready !== 1'b1) begin
            failures++;
            $display("FAIL addi_ready got=%b exp=1", bus.id_ready);
        end
        tick();
        checks++;
        if ({bus.idex_valid, bus.idex_imm, bus.idex_rd, bus.idex_we} !== {1'b1, 32'hFFFFFFFF, 5'd5, 1'b1}) begin
            failures++;
            $display("FAIL addi_fields got=%b/%h/%0d/%b exp=1/ffffffff/5/1",
                     bus.idex_valid, bus.idex_imm, bus.idex_rd, bus.idex_we);
        end
        checks++;
        if (dut_now() !== m) begin
            failures++;
            $display("FAIL addi_model got=%h exp=%h", dut_now(), m);
        end
        idle();
    endtask

    task automatic test_bypass_priority();
        regs[1] = 32'h11;
        regs[2] = 32'h22;
        present(I_ADD_X3, 32'h140);
        bus.wb_we = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'hAA;
        tick();
        checks++;
        if ({bus.idex_rs1_val, bus.idex_rs2_val} !== {32'hAA, 32'h22}) begin
            failures++;
            $display("FAIL byp_wb got=%h/%h exp=aa/22", bus.idex_rs1_val, bus.idex_rs2_val);
        end
        bus.mem_we = 1'b1; bus.mem_rd = 5'd1; bus.mem_data = 32'hBB;
        tick();
        checks++;
        if (bus.idex_rs1_val !== 32'hBB) begin
            failures++;
            $display("FAIL byp_mem got=%h exp=bb", bus.idex_rs1_val);
        end
        present(I_ADDI_X1_5, 32'h144);
        tick();
        present(I_ADD_X3, 32'h148);
        bus.ex_result = 32'hCC;
        tick();
        checks++;
        if (bus.idex_rs1_val !== 32'hCC) begin
            failures++;
            $display("FAIL byp_ex got=%h exp=cc", bus.idex_rs1_val);
        end
        checks++;
        if (dut_now() !== m) begin
            failures++;
            $display("FAIL byp_model got=%h exp=%h", dut_now(), m);
        end
        idle();
    endtask

    task automatic test_load_use();
        logic [31:0] s0;
        present(I_LW_X4, 32'h200);
        tick();
        present(I_ADD_X6, 32'h204);
        #1;
        checks++;
        if (bus.id_ready !== 1'b0) begin
            failures++;
            $display("FAIL lu_ready_stall got=%b exp=0", bus.id_ready);
        end
        s0 = m_stall;
        tick();
        checks++;
        if ({bus.idex_valid, bus.stall_count} !== {1'b0, s0 + 32'd1}) begin
            failures++;
            $display("FAIL lu_bubble got=%b/%0d exp=0/%0d", bus.idex_valid, bus.stall_count, s0 + 1);
        end
        bus.mem_we = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (bus.id_ready !== 1'b1) begin
            failures++;
            $display("FAIL lu_ready_after got=%b exp=1", bus.id_ready);
        end
        tick();
        checks++;
        if ({bus.idex_valid, bus.idex_rd, bus.idex_rs1_val, bus.idex_rs2_val, bus.stall_count}
            !== {1'b1, 5'd6, 32'hDEADBEEF, 32'hDEADBEEF, s0 + 32'd1}) begin
            failures++;
            $display("FAIL lu_issue got=%b/%0d/%h/%h/%0d exp=1/6/deadbeef/deadbeef/%0d",
                     bus.idex_valid, bus.idex_rd, bus.idex_rs1_val, bus.idex_rs2_val,
                     bus.stall_count, s0 + 1);
        end
        idle();
    endtask

    task automatic test_load_lui();
        logic [31:0] s0;
        present(I_LW_X4, 32'h300);
        tick();
        present(I_LUI_X4, 32'h304);
        #1;
        checks++;
        if (bus.id_ready !== 1'b1) begin
            failures++;
            $display("FAIL lui_ready got=%b exp=1", bus.id_ready);
        end
        s0 = m_stall;
        tick();
        checks++;
        if ({bus.idex_valid, bus.idex_imm, bus.stall_count} !== {1'b1, 32'h12345000, s0}) begin
            failures++;
            $display("FAIL lui_issue got=%b/%h/%0d exp=1/12345000/%0d",
                     bus.idex_valid, bus.idex_imm, bus.stall_count, s0);
        end
        idle();
    endtask

    task automatic test_hold();
        idex_t snap;
        present(I_ADDI_X5_M1, 32'h400);
        tick();
        snap = m;
        bus.ex_ready = 1'b0;
        present(I_ADDI_X7_3, 32'h404);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.id_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_ready[%0d] got=%b exp=0", i, bus.id_ready);
            end
            tick();
            checks++;
            if (dut_now() !== snap || bus.idex_rd !== 5'd5) begin
                failures++;
                $display("FAIL hold_fields[%0d] got=%h exp=%h", i, dut_now(), snap);
            end
        end
        bus.ex_ready = 1'b1;
        #1;
        checks++;
        if (bus.id_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release_ready got=%b exp=1", bus.id_ready);
        end
        tick();
        checks++;
        if ({bus.idex_valid, bus.idex_rd, bus.idex_pc} !== {1'b1, 5'd7, 32'h404}) begin
            failures++;
            $display("FAIL hold_release got=%b/%0d/%h exp=1/7/404", bus.idex_valid, bus.idex_rd, bus.idex_pc);
        end
        idle();
    endtask

    task automatic test_flush_stall();
        logic [31:0] s0;
        present(I_LW_X4, 32'h500);
        tick();
        present(I_ADD_X6, 32'h504);
        bus.flush = 1'b1;
        bus.ex_ready = 1'b0;
        #1;
        checks++;
        if (bus.id_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_ready got=%b exp=1", bus.id_ready);
        end
        s0 = m_stall;
        tick();
        checks++;
        if ({bus.idex_valid, bus.stall_count} !== {1'b0, s0}) begin
            failures++;
            $display("FAIL flush_result got=%b/%0d exp=0/%0d", bus.idex_valid, bus.stall_count, s0);
        end
        idle();
    endtask

    task automatic test_async_reset();
        present(I_LW_X4, 32'h600);
        tick();
        present(I_ADD_X6, 32'h604);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dut_now(), bus.stall_count} !== {idex_t'(0), 32'h0}) begin
            failures++;
            $display("FAIL async_reset got=%h/%h exp=0/0", dut_now(), bus.stall_count);
        end
        m = '0;
        m_stall = '0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_random();
        logic [6:0] ops [12] = '{O_LOAD, O_LOAD, O_IMM, O_JALR, O_STORE, O_BRANCH,
                                 O_LUI, O_AUIPC, O_JAL, O_REG, 7'b0001111, 7'b1111111};
        logic [31:0] ins;
        logic [31:0] pc = 32'h1000;
        logic took = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        for (int c = 0; c < 600; c++) begin
            if (took || !bus.if_valid) begin
                ins = $urandom;
                ins[6:0] = ops[$urandom_range(0, 11)];
                ins[11:7] = 5'($urandom_range(0, 7));
                ins[19:15] = 5'($urandom_range(0, 7));
                ins[24:20] = 5'($urandom_range(0, 7));
                pc = pc + 4;
                bus.if_valid = ($urandom % 4) != 0;
                bus.if_instr = ins;
                bus.if_pc = pc;
            end
            bus.ex_ready = ($urandom % 4) != 0;
            bus.flush = ($urandom % 16) == 0;
            bus.ex_result = $urandom;
            bus.mem_we = $urandom % 2; bus.mem_rd = 5'($urandom_range(0, 7)); bus.mem_data = $urandom;
            bus.wb_we = $urandom % 2;  bus.wb_rd = 5'($urandom_range(0, 7));  bus.wb_data = $urandom;
            #1;
            checks++;
            if ({bus.id_ready, bus.rf_ra1, bus.rf_ra2} !== {ref_ready(), bus.if_instr[19:15], bus.if_instr[24:20]}) begin
                failures++;
                $display("FAIL rnd_comb[%0d] got=%b/%0d/%0d exp=%b/%0d/%0d", c, bus.id_ready,
                         bus.rf_ra1, bus.rf_ra2, ref_ready(), bus.if_instr[19:15], bus.if_instr[24:20]);
            end
            took = ref_ready();
            tick();
            checks++;
            if (bus.stall_count !== m_stall || bus.idex_valid !== m.valid ||
                (m.valid && dut_now() !== m)) begin
                failures++;
                $display("FAIL rnd_idex[%0d] got=%h/%0d exp=%h/%0d", c, dut_now(), bus.stall_count, m, m_stall);
            end
        end
        idle();
    endtask

    initial begin
        m = '0;
        m_stall = '0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
        test_reset();
        test_addi();
        test_bypass_priority();
        test_load_use();
        test_load_lui();
        test_hold();
        test_flush_stall();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
